// File: rtl/im_port_arbiter.sv
// im_port_arbiter: shares the single-port instruction RAM between the fetch
// stage and the boot/debug loader. One access is granted per cycle. Each read
// is tagged so that the RAM output goes back to the right requester on the
// following cycle. A fetched word is squashed to a nop when its fetch carried
// an exception.
module im_port_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int LBURST_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_mode,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_exc,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [3:0]        l_be,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int                CNT_W     = $clog2(LBURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(LBURST_MAX);

    // Owner of the word the RAM returns on the current cycle.
    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_FETCH = 2'd1,
        RSP_LOAD  = 2'd2
    } rsp_t;

    rsp_t             rsp, rsp_next;
    logic             exc_q;
    logic [CNT_W-1:0] burst_cnt, burst_next;

    // Grant decision: boot mode hands the RAM to the loader. Under contention
    // the loader wins until it has taken LBURST_MAX grants in a row.
    always_comb begin
        // NOTE: every combinational output gets a default first, so that no
        // branch can leave one unassigned and infer a latch.
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!reset) begin
            if (boot_mode) begin
                l_gnt = l_req;
            end else if (f_req && l_req) begin
                if (burst_cnt == BURST_LIM) f_gnt = 1'b1;
                else                        l_gnt = 1'b1;
            end else begin
                f_gnt = f_req;
                l_gnt = l_req;
            end
        end
    end

    // RAM drive: the winner's address, and write strobes only for a loader write.
    // When nothing is granted the fetch address idles on the bus.
    always_comb begin
        ram_addr = l_gnt ? l_addr : f_addr;
        ram_we   = 4'b0000;
        ram_din  = '0;
        if (l_gnt && l_we) begin
            ram_we  = l_be;
            ram_din = l_wdata;
        end
    end

    // Next state of the burst counter and the response tag.
    always_comb begin
        burst_next = burst_cnt;
        if (boot_mode || !f_req || f_gnt)
            burst_next = '0;
        else if (l_gnt && burst_cnt != BURST_LIM)
            burst_next = burst_cnt + 1'b1;

        rsp_next = RSP_NONE;
        if (f_gnt)
            rsp_next = RSP_FETCH;
        else if (l_gnt && !l_we)
            rsp_next = RSP_LOAD;
    end

    // State registers. An async reset drops any in-flight response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp       <= RSP_NONE;
            exc_q     <= 1'b0;
            burst_cnt <= '0;
        end else begin
            // NOTE: use non-blocking assignments for all state, so that every
            // register samples values from before the clock edge.
            rsp       <= rsp_next;
            burst_cnt <= burst_next;
            if (f_gnt) exc_q <= f_exc;
        end
    end

    // Response steering: the RAM word goes to the owner recorded in the tag.
    // A non-valid port reads as zero.
    always_comb begin
        f_rvalid = (rsp == RSP_FETCH);
        l_rvalid = (rsp == RSP_LOAD);
        f_rdata  = (f_rvalid && !exc_q) ? ram_dout : '0;
        l_rdata  = l_rvalid ? ram_dout : '0;
    end

endmodule

// File: tb/tb_im_port_arbiter.sv
// tb_im_port_arbiter: directed test of im_port_arbiter. It drives a
// behavioural 1-cycle synchronous RAM with byte enables. Every expected value
// below is worked out by hand from the preload pattern RAM[i] = 32'hC0DE_0000 + i.
module tb_im_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        boot_mode;
    logic        f_req;
    logic [12:0] f_addr;
    logic        f_exc;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        l_req;
    logic        l_we;
    logic [3:0]  l_be;
    logic [12:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_gnt;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic [3:0]  ram_we;
    logic [12:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = 32'h0;

    logic [31:0] mem [0:8191];

    int checks   = 0;
    int failures = 0;

    im_port_arbiter #(.ADDR_W(13), .DATA_W(32), .LBURST_MAX(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .boot_mode (boot_mode),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_exc     (f_exc),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_be      (l_be),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .l_rvalid  (l_rvalid),
        .l_rdata   (l_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // Instruction RAM model: byte-enabled write, registered read.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge. Inputs are driven there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'hC0DE_0000 + i;
        reset = 1'b1; boot_mode = 1'b0;
        f_req = 1'b1; f_addr = 13'h004; f_exc = 1'b0;
        l_req = 1'b1; l_we = 1'b0; l_be = 4'h0; l_addr = 13'h000; l_wdata = 32'h0;
        tick(); tick();
        #1;
        // Reset state: both grants are forced low, and nothing is valid.
        check("rst_f_gnt",    32'(f_gnt),    0);
        check("rst_l_gnt",    32'(l_gnt),    0);
        check("rst_f_rvalid", 32'(f_rvalid), 0);
        check("rst_l_rvalid", 32'(l_rvalid), 0);
        check("rst_burst",    32'(dut.burst_cnt), 0);
        check("rst_ram_we",   32'(ram_we),   0);
        tick();
        reset = 1'b0; l_req = 1'b0; f_req = 1'b0;
        tick();

        // Fetch only: granted on the same cycle, data back next cycle.
        f_req = 1'b1; f_addr = 13'h004;
        #1;
        check("t1_f_gnt",    32'(f_gnt),    1);
        check("t1_l_gnt",    32'(l_gnt),    0);
        check("t1_ram_addr", 32'(ram_addr), 32'h004);
        tick();
        f_req = 1'b0;
        #1;
        check("t1_f_rvalid", 32'(f_rvalid), 1);
        check("t1_f_rdata",  f_rdata,       32'hC0DE_0004);
        check("t1_l_rvalid", 32'(l_rvalid), 0);

        // Exception: the returned word is squashed to a nop.
        f_req = 1'b1; f_exc = 1'b1;
        tick();
        f_req = 1'b0; f_exc = 1'b0;
        #1;
        check("t2_f_rvalid", 32'(f_rvalid), 1);
        check("t2_f_rdata",  f_rdata,       32'h0);
        tick();
        check("t2_idle_rvalid", 32'(f_rvalid), 0);

        // Contention for 12 cycles: 8 loader grants, then 1 fetch grant, then 3 loader grants.
        f_req = 1'b1; f_addr = 13'h008;
        l_req = 1'b1; l_we = 1'b0; l_addr = 13'h020;
        for (int i = 0; i < 12; i++) begin
            #1;
            check($sformatf("t3_f_gnt_%0d", i), 32'(f_gnt), (i == 8) ? 1 : 0);
            check($sformatf("t3_l_gnt_%0d", i), 32'(l_gnt), (i == 8) ? 0 : 1);
            if (i == 8) check("t3_burst_sat", 32'(dut.burst_cnt), 8);
            if (i == 9) begin
                check("t3_f_rvalid", 32'(f_rvalid), 1);
                check("t3_f_rdata",  f_rdata,       32'hC0DE_0008);
            end else if (i > 0) begin
                check($sformatf("t3_l_rvalid_%0d", i), 32'(l_rvalid), 1);
                check($sformatf("t3_l_rdata_%0d", i),  l_rdata,       32'hC0DE_0020);
            end
            tick();
        end
        f_req = 1'b0; l_req = 1'b0;
        #1;
        check("t3_last_l_rvalid", 32'(l_rvalid), 1);
        check("t3_burst_clear",   32'(dut.burst_cnt), 3);
        tick();
        check("t3_burst_zero", 32'(dut.burst_cnt), 0);

        // Boot mode: the loader writes, and fetch stays blocked until boot mode drops.
        boot_mode = 1'b1;
        f_req = 1'b1; f_addr = 13'h010;
        l_req = 1'b1; l_we = 1'b1; l_be = 4'hF; l_addr = 13'h010; l_wdata = 32'hDEAD_BEEF;
        #1;
        check("t4_l_gnt",    32'(l_gnt),    1);
        check("t4_f_gnt",    32'(f_gnt),    0);
        check("t4_ram_we",   32'(ram_we),   32'hF);
        check("t4_ram_din",  ram_din,       32'hDEAD_BEEF);
        check("t4_ram_addr", 32'(ram_addr), 32'h010);
        tick();
        l_req = 1'b0; l_we = 1'b0;
        #1;
        check("t4_f_blocked",  32'(f_gnt),    0);
        check("t4_wr_no_rsp",  32'(l_rvalid), 0);
        check("t4_idle_ramwe", 32'(ram_we),   0);
        tick();
        boot_mode = 1'b0;
        #1;
        check("t4_f_gnt_after", 32'(f_gnt), 1);
        tick();
        f_req = 1'b0;
        #1;
        check("t4_f_rvalid", 32'(f_rvalid), 1);
        check("t4_f_rdata",  f_rdata,       32'hDEAD_BEEF);
        tick();

        // Partial write over a full write, then a read on the very next cycle.
        l_req = 1'b1; l_we = 1'b1; l_be = 4'hF; l_addr = 13'h030; l_wdata = 32'h1111_1111;
        tick();
        l_be = 4'b0011; l_wdata = 32'h0000_ABCD;
        #1;
        check("t5_ram_we_part", 32'(ram_we), 32'h3);
        tick();
        l_we = 1'b0; l_be = 4'h0; l_wdata = 32'h0;
        #1;
        check("t5_rd_gnt", 32'(l_gnt), 1);
        tick();
        l_req = 1'b0;
        #1;
        check("t5_l_rvalid", 32'(l_rvalid), 1);
        check("t5_l_rdata",  l_rdata,       32'h1111_ABCD);
        tick();

        // Boot mode rises while a fetch is in flight: the response is still delivered.
        f_req = 1'b1; f_addr = 13'h004;
        tick();
        boot_mode = 1'b1;
        #1;
        check("t7_f_gnt_boot", 32'(f_gnt),    0);
        check("t7_inflight_v", 32'(f_rvalid), 1);
        check("t7_inflight_d", f_rdata,       32'hC0DE_0004);
        boot_mode = 1'b0; f_req = 1'b0;
        tick();

        // Reset during contention clears burst_cnt and drops the pending loader response.
        f_req = 1'b1; f_addr = 13'h008; l_req = 1'b1; l_addr = 13'h020;
        tick(); tick();
        check("t6_burst_pre", 32'(dut.burst_cnt), 2);
        reset = 1'b1;
        #1;
        check("t6_burst_rst", 32'(dut.burst_cnt), 0);
        check("t6_l_rvalid",  32'(l_rvalid), 0);
        check("t6_l_rdata",   l_rdata,       32'h0);
        check("t6_l_gnt_rst", 32'(l_gnt),    0);
        check("t6_f_gnt_rst", 32'(f_gnt),    0);
        tick();
        reset = 1'b0; l_req = 1'b0;
        tick();
        // Reset the cycle after a fetch grant: no response, before or after release.
        f_req = 1'b0;
        #1;
        check("t6_f_v_after", 32'(f_rvalid), 1);
        f_req = 1'b1; f_addr = 13'h004;
        tick();
        f_req = 1'b0; reset = 1'b1;
        #1;
        check("t6_mid_f_rvalid", 32'(f_rvalid), 0);
        check("t6_mid_f_rdata",  f_rdata,       32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("t6_no_late_rsp", 32'(f_rvalid), 0);
        check("t6_no_late_l",   32'(l_rvalid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
